exec_div_seq: RTL and testbench

- Multi-cycle sequencer for integer division in the execute stage; single-cycle exec units stay combinational.
- Accepts one divide op by handshake and runs a W_OPR-step restoring shift/subtract loop on an internal remainder/quotient register pair.
- Returns quotient or remainder with the standard exec flag vector {overflow, sign, zero, carry}.
- Holds the result until the pipeline acknowledges it.

---
 rtl/exec_div_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_exec_div_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_div_seq.sv
// exec_div_seq: multi-cycle integer divide sequencer for the execute stage.
// Accepts one op by start/ready handshake, runs a W_OPR-step restoring
// shift/subtract loop, and holds the quotient or remainder with the exec
// flag vector {overflow, sign, zero, carry} until the consumer acks it.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   start_i    op request, accepted when start_i && ready_o
//   opr1_i     dividend, sampled at accept
//   opr2_i     divisor, sampled at accept
//   signed_i   1 = two's-complement divide, 0 = unsigned
//   sel_rem_i  1 = return remainder, 0 = quotient
//   abort_i    flush; kills any op in flight (wins over start_i/ack_i)
//   ack_i      consumer takes the result when valid_o && ack_i
//   ready_o    high in IDLE
//   busy_o     high in PREP, CALC, FIX
//   valid_o    high in DONE; result_o/flags_o valid
//   result_o   quotient or remainder
//   flags_o    {overflow, sign, zero, carry}
module exec_div_seq #(
    parameter int unsigned W_OPR   = 32,
    parameter int unsigned W_FLAGS = 4,
    parameter int unsigned W_CNT   = 6
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [W_OPR-1:0]   opr1_i,
    input  logic [W_OPR-1:0]   opr2_i,
    input  logic               signed_i,
    input  logic               sel_rem_i,
    input  logic               abort_i,
    input  logic               ack_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               valid_o,
    output logic [W_OPR-1:0]   result_o,
    output logic [W_FLAGS-1:0] flags_o
);

    localparam int unsigned FLAG_OVF  = 3;
    localparam int unsigned FLAG_SIGN = 2;
    localparam int unsigned FLAG_ZERO = 1;
    localparam int unsigned FLAG_CARRY = 0;

    localparam logic [W_OPR-1:0] INT_MIN   = {1'b1, {(W_OPR-1){1'b0}}};
    localparam logic [W_CNT-1:0] CNT_START = W_CNT'(W_OPR - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Datapath registers: dvd_q holds the dividend and shifts into the quotient.
    logic [W_OPR-1:0]   dvd_q,   dvd_d;
    logic [W_OPR-1:0]   dvs_q,   dvs_d;
    logic [W_OPR-1:0]   rem_q,   rem_d;
    logic [W_CNT-1:0]   cnt_q,   cnt_d;
    logic               sgn_q,   sgn_d;
    logic               rsel_q,  rsel_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [W_OPR-1:0]   result_d;
    logic [W_FLAGS-1:0] flags_d;
    logic               ready_d, busy_d, valid_d;

    // Accept-cycle decode of the two special cases.
    logic div_zero_c;
    logic int_ovf_c;
    logic accept_c;

    assign div_zero_c = (opr2_i == '0);
    assign int_ovf_c  = signed_i && (opr1_i == INT_MIN) && (opr2_i == '1);
    assign accept_c   = start_i && !abort_i && (state_q == S_IDLE);

    // One restoring step: remainder gets the next dividend bit, then trial-subtract.
    logic [W_OPR:0]   rem_sh_c;
    logic             ge_c;
    logic [W_OPR-1:0] sub_c;

    assign rem_sh_c = {rem_q, dvd_q[W_OPR-1]};
    assign ge_c     = (rem_sh_c >= {1'b0, dvs_q});
    assign sub_c    = rem_sh_c[W_OPR-1:0] - dvs_q;

    // Sign fix-up of the magnitude results.
    logic [W_OPR-1:0] quo_fix_c;
    logic [W_OPR-1:0] rem_fix_c;

    assign quo_fix_c = neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
    assign rem_fix_c = neg_r_q ? (~rem_q + 1'b1) : rem_q;

    function automatic logic [W_FLAGS-1:0] mk_flags(input logic ovf, input logic [W_OPR-1:0] res);
        logic [W_FLAGS-1:0] f;
        f             = '0;
        f[FLAG_OVF]   = ovf;
        f[FLAG_SIGN]  = res[W_OPR-1];
        f[FLAG_ZERO]  = ~|res;
        f[FLAG_CARRY] = 1'b0;
        return f;
    endfunction

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = (div_zero_c || int_ovf_c) ? S_DONE : S_PREP;
                    end
                end
                S_PREP: state_d = S_CALC;
                S_CALC: begin
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX:  state_d = S_DONE;
                S_DONE: begin
                    if (ack_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath next-value logic.
    always_comb begin
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        rsel_d   = rsel_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_o;
        flags_d  = flags_o;

        ready_d  = (state_d == S_IDLE);
        busy_d   = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
        valid_d  = (state_d == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    dvd_d  = opr1_i;
                    dvs_d  = opr2_i;
                    sgn_d  = signed_i;
                    rsel_d = sel_rem_i;
                    if (div_zero_c) begin
                        result_d = sel_rem_i ? opr1_i : '1;
                        flags_d  = mk_flags(1'b1, sel_rem_i ? opr1_i : '1);
                    end else if (int_ovf_c) begin
                        // Remainder of INT_MIN / -1 is exact; only the quotient overflows.
                        result_d = sel_rem_i ? '0 : INT_MIN;
                        flags_d  = mk_flags(!sel_rem_i, sel_rem_i ? '0 : INT_MIN);
                    end
                end
            end
            S_PREP: begin
                if (sgn_q) begin
                    dvd_d = dvd_q[W_OPR-1] ? (~dvd_q + 1'b1) : dvd_q;
                    dvs_d = dvs_q[W_OPR-1] ? (~dvs_q + 1'b1) : dvs_q;
                end
                neg_q_d = sgn_q && (dvd_q[W_OPR-1] ^ dvs_q[W_OPR-1]);
                neg_r_d = sgn_q && dvd_q[W_OPR-1];
                rem_d   = '0;
                cnt_d   = CNT_START;
            end
            S_CALC: begin
                rem_d = ge_c ? sub_c : rem_sh_c[W_OPR-1:0];
                dvd_d = {dvd_q[W_OPR-2:0], ge_c};
                cnt_d = cnt_q - 1'b1;
            end
            S_FIX: begin
                result_d = rsel_q ? rem_fix_c : quo_fix_c;
                flags_d  = mk_flags(1'b0, rsel_q ? rem_fix_c : quo_fix_c);
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            rsel_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            rsel_q   <= rsel_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_o <= result_d;
            flags_o  <= flags_d;
            ready_o  <= ready_d;
            busy_o   <= busy_d;
            valid_o  <= valid_d;
        end
    end

endmodule

// File: tb/tb_exec_div_seq.sv
// Testbench for exec_div_seq: directed vector table, hand-written abort and
// reset sequences, and randomized ops checked against an arithmetic model.
module tb_exec_div_seq;

    localparam int unsigned W         = 32;
    localparam int unsigned LAT_NORM  = W + 2;
    // Special cases enter DONE on the accept edge itself.
    localparam int unsigned LAT_SPEC  = 0;
    localparam int unsigned LAT_LIMIT = 100;
    localparam int unsigned N_RAND    = 40;

    logic         clk_i     = 1'b0;
    logic         rst_n_i   = 1'b1;
    logic         start_i   = 1'b0;
    logic [W-1:0] opr1_i    = '0;
    logic [W-1:0] opr2_i    = '0;
    logic         signed_i  = 1'b0;
    logic         sel_rem_i = 1'b0;
    logic         abort_i   = 1'b0;
    logic         ack_i     = 1'b0;
    logic         ready_o;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] result_o;
    logic [3:0]   flags_o;

    int n_chk  = 0;
    int n_fail = 0;

    exec_div_seq #(.W_OPR(W), .W_FLAGS(4), .W_CNT(6)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (start_i),
        .opr1_i    (opr1_i),
        .opr2_i    (opr2_i),
        .signed_i  (signed_i),
        .sel_rem_i (sel_rem_i),
        .abort_i   (abort_i),
        .ack_i     (ack_i),
        .ready_o   (ready_o),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .flags_o   (flags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sg;
        logic         sr;
        logic [W-1:0] res;
        logic [3:0]   fl;
        int unsigned  lat;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the two architectural special cases.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sg, input logic sr,
                                    output logic [W-1:0] res, output logic [3:0] fl);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        ovf = 1'b0;
        if (b == '0) begin
            q = '1; r = a; ovf = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0; ovf = !sr;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        res = sr ? r : q;
        fl  = {ovf, res[W-1], (res == '0), 1'b0};
    endfunction

    // Issue one op; poke_at >= 0 raises a stray start_i that cycle while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sg, input logic sr, input int poke_at,
                          output logic [W-1:0] res, output logic [3:0] fl,
                          output int unsigned lat);
        opr1_i = a; opr2_i = b; signed_i = sg; sel_rem_i = sr; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        opr1_i = $urandom; opr2_i = $urandom; signed_i = 1'($urandom); sel_rem_i = 1'($urandom);
        lat = 0;
        while (!valid_o && lat < LAT_LIMIT) begin
            @(posedge clk_i); #1;
            lat++;
            start_i = (int'(lat) == poke_at);
        end
        start_i = 1'b0;
        res = result_o;
        fl  = flags_o;
    endtask

    task automatic do_ack(input string name);
        ack_i = 1'b1;
        @(posedge clk_i); #1;
        ack_i = 1'b0;
        chk({name, "_ack_valid"}, W'(valid_o), W'(0));
        chk({name, "_ack_ready"}, W'(ready_o), W'(1));
    endtask

    vec_t         vecs[15];
    logic [W-1:0] res;
    logic [3:0]   fl;
    int unsigned  lat;
    logic [W-1:0] e_res;
    logic [3:0]   e_fl;
    int           seen;

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        4'b0000, LAT_NORM};
        vecs[1]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd2,         4'b0000, LAT_NORM};
        vecs[2]  = '{32'hFFFF_FF9C, 32'd7,         1'b1, 1'b0, 32'hFFFF_FFF2, 4'b0100, LAT_NORM};
        vecs[3]  = '{32'hFFFF_FF9C, 32'd7,         1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0100, LAT_NORM};
        vecs[4]  = '{32'd100,       32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFF2, 4'b0100, LAT_NORM};
        vecs[5]  = '{32'd100,       32'hFFFF_FFF9, 1'b1, 1'b1, 32'd2,         4'b0000, LAT_NORM};
        vecs[6]  = '{32'd5,         32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1100, LAT_SPEC};
        vecs[7]  = '{32'd5,         32'd0,         1'b0, 1'b1, 32'd5,         4'b1000, LAT_SPEC};
        vecs[8]  = '{32'd5,         32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF, 4'b1100, LAT_SPEC};
        vecs[9]  = '{32'd5,         32'd0,         1'b1, 1'b1, 32'd5,         4'b1000, LAT_SPEC};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 4'b1100, LAT_SPEC};
        vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0,         4'b0010, LAT_SPEC};
        vecs[12] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0,         4'b0010, LAT_NORM};
        vecs[13] = '{32'd0,         32'd5,         1'b1, 1'b1, 32'd0,         4'b0010, LAT_NORM};
        vecs[14] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0100, LAT_NORM};

        // Reset state.
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_valid",  W'(valid_o), W'(0));
        chk("rst_busy",   W'(busy_o),  W'(0));
        chk("rst_result", result_o,    W'(0));
        chk("rst_flags",  W'(flags_o), W'(0));
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_ready", W'(ready_o), W'(1));

        // Directed vectors.
        foreach (vecs[i]) begin
            chk($sformatf("vec%0d_ready", i), W'(ready_o), W'(1));
            run_op(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].sr, -1, res, fl, lat);
            chk($sformatf("vec%0d_lat", i),   W'(lat), W'(vecs[i].lat));
            chk($sformatf("vec%0d_res", i),   res,     vecs[i].res);
            chk($sformatf("vec%0d_flags", i), W'(fl),  W'(vecs[i].fl));
            do_ack($sformatf("vec%0d", i));
        end

        // abort + start in IDLE: nothing accepted.
        abort_i = 1'b1; start_i = 1'b1; opr1_i = 32'd9; opr2_i = 32'd3;
        @(posedge clk_i); #1;
        abort_i = 1'b0; start_i = 1'b0;
        chk("idle_abort_ready", W'(ready_o), W'(1));
        chk("idle_abort_busy",  W'(busy_o),  W'(0));

        // Abort at CALC step 10 with start_i also high.
        opr1_i = 32'd100; opr2_i = 32'd7; signed_i = 1'b0; sel_rem_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        chk("calc_busy",  W'(busy_o),  W'(1));
        chk("calc_ready", W'(ready_o), W'(0));
        repeat (10) @(posedge clk_i);
        #1;
        abort_i = 1'b1; start_i = 1'b1; opr1_i = 32'd50; opr2_i = 32'd5;
        @(posedge clk_i); #1;
        abort_i = 1'b0; start_i = 1'b0;
        chk("abort_ready", W'(ready_o), W'(1));
        chk("abort_busy",  W'(busy_o),  W'(0));
        chk("abort_valid", W'(valid_o), W'(0));
        seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o || !ready_o) seen++;
        end
        chk("abort_quiet", W'(seen), W'(0));

        // 9/3 with a stray start mid-op, then ack held low for 5 cycles.
        run_op(32'd9, 32'd3, 1'b0, 1'b0, 5, res, fl, lat);
        chk("op93_lat",   W'(lat), W'(LAT_NORM));
        chk("op93_res",   res,     W'(3));
        chk("op93_flags", W'(fl),  W'(0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("hold%0d_valid", k), W'(valid_o), W'(1));
            chk($sformatf("hold%0d_res", k),   result_o,    W'(3));
            chk($sformatf("hold%0d_flags", k), W'(flags_o), W'(0));
        end
        do_ack("op93");

        // Asynchronous reset mid-CALC.
        opr1_i = 32'd77; opr2_i = 32'd5; signed_i = 1'b0; sel_rem_i = 1'b0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (15) @(posedge clk_i);
        #3 rst_n_i = 1'b0;
        #1;
        chk("arst_valid",  W'(valid_o), W'(0));
        chk("arst_busy",   W'(busy_o),  W'(0));
        chk("arst_result", result_o,    W'(0));
        chk("arst_flags",  W'(flags_o), W'(0));
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        chk("arst_ready", W'(ready_o), W'(1));
        run_op(32'd1000, 32'd10, 1'b0, 1'b0, -1, res, fl, lat);
        chk("op1000_lat",   W'(lat), W'(LAT_NORM));
        chk("op1000_res",   res,     W'(100));
        chk("op1000_flags", W'(fl),  W'(0));
        do_ack("op1000");

        // Randomized ops against the reference model.
        for (int n = 0; n < int'(N_RAND); n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         sg;
            logic         sr;
            int unsigned  e_lat;
            a  = $urandom;
            b  = $urandom;
            sg = 1'($urandom);
            sr = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = W'($urandom_range(1, 15));
                3: b = {{(W-4){b[3]}}, b[3:0]};
                4: a = W'($urandom_range(0, 3));
                default: ;
            endcase
            ref_div(a, b, sg, sr, e_res, e_fl);
            e_lat = ((b == '0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? LAT_SPEC : LAT_NORM;
            run_op(a, b, sg, sr, -1, res, fl, lat);
            chk($sformatf("rnd%0d_lat a=%h b=%h s=%0d r=%0d", n, a, b, sg, sr), W'(lat), W'(e_lat));
            chk($sformatf("rnd%0d_res a=%h b=%h s=%0d r=%0d", n, a, b, sg, sr), res, e_res);
            chk($sformatf("rnd%0d_flags a=%h b=%h s=%0d r=%0d", n, a, b, sg, sr), W'(fl), W'(e_fl));
            do_ack($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
